// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, runs mult/multu/div/divu over a fixed
// latency and performs mthi/mtlo in a single cycle.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    // Counter only ever holds latency-1, so clog2(latency) bits are enough.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [CNT_W-1:0] count_r;
    logic [2:0]      op_r;
    logic [31:0]     a_r;
    logic [31:0]     b_r;
    logic            busy_r;
    logic [31:0]     hi_r;
    logic [31:0]     lo_r;

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_sdiv_s;
    logic [31:0] b_udiv_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        commit_en_s;

    // Result datapath from the latched operands; signed divide works on
    // magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        prod_signed_s   = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
        prod_unsigned_s = {32'd0, a_r} * {32'd0, b_r};
        a_mag_s  = a_r[31] ? (32'd0 - a_r) : a_r;
        b_mag_s  = b_r[31] ? (32'd0 - b_r) : b_r;
        b_sdiv_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        b_udiv_s = (b_r == 32'd0) ? 32'd1 : b_r;
        q_mag_s  = a_mag_s / b_sdiv_s;
        r_mag_s  = a_mag_s % b_sdiv_s;
        quo_s    = (a_r[31] ^ b_r[31]) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s    = a_r[31] ? (32'd0 - r_mag_s) : r_mag_s;
        uquo_s   = a_r / b_udiv_s;
        urem_s   = a_r % b_udiv_s;
        res_hi_s    = hi_r;
        res_lo_s    = lo_r;
        commit_en_s = 1'b0;
        case (op_r)
            OP_MULT: begin
                res_hi_s    = prod_signed_s[63:32];
                res_lo_s    = prod_signed_s[31:0];
                commit_en_s = 1'b1;
            end
            OP_MULTU: begin
                res_hi_s    = prod_unsigned_s[63:32];
                res_lo_s    = prod_unsigned_s[31:0];
                commit_en_s = 1'b1;
            end
            OP_DIV: begin
                res_hi_s    = rem_s;
                res_lo_s    = quo_s;
                commit_en_s = (b_r != 32'd0);
            end
            OP_DIVU: begin
                res_hi_s    = urem_s;
                res_lo_s    = uquo_s;
                commit_en_s = (b_r != 32'd0);
            end
            default: begin
                commit_en_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: issue, countdown and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            busy_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                op_r    <= md_op;
                                a_r     <= a;
                                b_r     <= b;
                                count_r <= MULT_LOAD;
                                state_r <= ST_RUN;
                                busy_r  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_r    <= md_op;
                                a_r     <= a;
                                b_r     <= b;
                                count_r <= DIV_LOAD;
                                state_r <= ST_RUN;
                                busy_r  <= 1'b1;
                            end
                            OP_MTHI: hi_r <= a;
                            OP_MTLO: lo_r <= a;
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (commit_en_s) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end else begin
                            hi_r <= hi_r;
                        end
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed sequences, a vector table and
// randomized traffic against a cycle-level arithmetic reference model.
module tb_md_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[13];

    // reference model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pok;
    int          m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic cn);
        start = 1'b1; md_op = op; a = av; b = bv; cancel = cn;
        tick();
        start = 1'b0; md_op = 3'd0; cancel = 1'b0;
    endtask

    // Architectural result of an md operation, from 64-bit integer arithmetic.
    task automatic ref_result(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                              output logic [31:0] rh, output logic [31:0] rl, output logic ok);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(av); sb = $signed(bv);
        ua = av; ub = bv;
        rh = 32'd0; rl = 32'd0; ok = 1'b1;
        case (op)
            3'd1: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            3'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
            3'd3: begin
                if (bv == 32'd0) ok = 1'b0;
                else begin sq = sa / sb; sr = sa % sb; rh = sr[31:0]; rl = sq[31:0]; end
            end
            3'd4: begin
                if (bv == 32'd0) ok = 1'b0;
                else begin rh = 32'(ua % ub); rl = 32'(ua / ub); end
            end
            default: ok = 1'b0;
        endcase
    endtask

    task automatic model_step(input logic st, input logic [2:0] op, input logic [31:0] av,
                              input logic [31:0] bv, input logic cn);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pok) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else if (st && !cn) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                ref_result(op, av, bv, m_phi, m_plo, m_pok);
                m_left = (op <= 3'd2) ? MC : DC;
            end else if (op == 3'd5) begin
                m_hi = av;
            end else if (op == 3'd6) begin
                m_lo = av;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF; sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] prev_hi, prev_lo;
        int cnt;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[4]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
        vecs[5]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC};
        vecs[6]  = '{3'd3, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[7]  = '{3'd3, 32'h10,       32'h0,        32'h00000001, 32'hFFFFFFFD, DC};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vecs[9]  = '{3'd2, 32'h80000000, 32'h2,        32'h00000001, 32'h00000000, MC};
        vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, MC};
        vecs[11] = '{3'd5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 0};
        vecs[12] = '{3'd6, 32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678, 0};

        tick(); tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        // mthi/mtlo then divide by zero leaves HI/LO alone
        issue(3'd5, 32'h11, 32'h0, 1'b0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h22, 32'h0, 1'b0);
        check("mtlo_hi", hi, 32'h11);
        check("mtlo_lo", lo, 32'h22);
        issue(3'd4, 32'd7, 32'd0, 1'b0);
        cnt = 0;
        while (busy && cnt < 40) begin tick(); cnt++; end
        check("div0_cycles", cnt, DC);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // single-cycle mthi, cancelled mtlo
        issue(3'd5, 32'h1234, 32'h0, 1'b0);
        check("mthi2_hi", hi, 32'h1234);
        check("mthi2_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h5555, 32'h0, 1'b1);
        check("mtlo_cancel_lo", lo, 32'h22);
        issue(3'd1, 32'd3, 32'd4, 1'b1);
        check("mult_cancel_busy", {31'd0, busy}, 32'd0);

        // mid-RUN issues ignored, then async reset drops the pending result
        issue(3'd1, 32'd5, 32'd6, 1'b0);
        check("midrun_busy0", {31'd0, busy}, 32'd1);
        issue(3'd6, 32'hAA, 32'h0, 1'b1);
        check("midrun_lo1", lo, 32'h22);
        issue(3'd6, 32'hBB, 32'h0, 1'b0);
        check("midrun_lo2", lo, 32'h22);
        check("midrun_busy2", {31'd0, busy}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        tick(); reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("no_commit_hi", hi, 32'd0);
        check("no_commit_lo", lo, 32'd0);
        check("no_commit_busy", {31'd0, busy}, 32'd0);

        // vector table
        prev_hi = 32'd0; prev_lo = 32'd0;
        for (int v = 0; v < 13; v++) begin
            issue(vecs[v].op, vecs[v].a, vecs[v].b, 1'b0);
            cnt = 0;
            while (busy && cnt < 40) begin
                check($sformatf("v%0d_hold_hi", v), hi, prev_hi);
                check($sformatf("v%0d_hold_lo", v), lo, prev_lo);
                tick();
                cnt++;
            end
            check($sformatf("v%0d_cycles", v), cnt, vecs[v].cycles);
            check($sformatf("v%0d_hi", v), hi, vecs[v].exp_hi);
            check($sformatf("v%0d_lo", v), lo, vecs[v].exp_lo);
            prev_hi = vecs[v].exp_hi; prev_lo = vecs[v].exp_lo;
        end

        // randomized traffic against the reference model
        reset = 1'b1; tick(); reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pok = 1'b0; m_phi = 32'd0; m_plo = 32'd0;
        for (int c = 0; c < 1500; c++) begin
            start  = ($urandom_range(1) == 1);
            md_op  = 3'($urandom_range(7));
            a      = pick();
            b      = ($urandom_range(7) == 0) ? 32'd0 : pick();
            cancel = ($urandom_range(6) == 0);
            tick();
            model_step(start, md_op, a, b, cancel);
            check("rnd_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("rnd_hi", hi, m_hi);
            check("rnd_lo", lo, m_lo);
        end
        start = 1'b0; cancel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO registers and executes mult/multu/div/divu over a fixed multi-cycle latency.
- Handles mthi/mtlo in one cycle.
- Issued from the E stage. Drives `busy`, which the pipeline stall logic combines with `start` to hold any md-class instruction in D.
- Honours an exception flush so that an E-stage instruction cancelled by an interrupt does not commit.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy is held for div/divu (>=1).

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe, high for one cycle while an md-class instruction sits in E.
- md_op  input  3  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo; 0 and 7 are no-ops.
- a  input  32  forwarded rs value from E.
- b  input  32  forwarded rt value from E.
- cancel  input  1  exception/interrupt flush of the E-stage instruction.
- busy  output  1  operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, busy=0, hi=0, lo=0, latched operands=0.
- States:
  - IDLE: accepts issue.
  - RUN: counting down; result is pending.
- Issue condition: clock edge in IDLE with start=1 and cancel=0.
- md_op 1..4 at issue:
  - Latch a, b and op.
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Go to RUN; busy=1 from the next cycle.
- md_op 5 or 6 at issue: write a to hi or lo at that edge. State stays IDLE and busy stays 0.
- md_op 0 or 7 at issue: no effect.
- RUN:
  - Each edge decrements the counter.
  - At the edge where the counter is 0: commit the result to hi/lo, go to IDLE, busy=0.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - The first cycle a dependent mfhi/mflo can read new hi/lo is the cycle busy falls.
- hi/lo hold their old values throughout RUN. They never show partial results.
- start while in RUN: ignored entirely, including mthi/mtlo. The stall logic prevents this; the sequencer must still not corrupt state.
- cancel=1 together with start: the issue is suppressed with no state change. This applies to mthi/mtlo too.
- cancel during RUN: ignored. The operation was committed at issue and completes normally.
- Arithmetic:
  - mult: {hi,lo} = signed a * signed b, full 64 bits.
  - multu: {hi,lo} = unsigned a * unsigned b, full 64 bits.
  - div: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b=0): hi/lo unchanged. busy is still held for DIV_CYCLES. No exception is raised.
- Results may be computed combinationally from the latched operands. Only the commit timing is architectural.
- Reset asserted mid-RUN: returns to IDLE at once, busy=0, hi=lo=0. The pending result is lost.

Test Plan:
- Reset, then start md_op=1 a=0xFFFFFFFE (-2) b=3 -> busy high exactly 5 cycles, hi/lo stay 0 meanwhile; on the edge busy falls, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- md_op=2 a=0xFFFFFFFF b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- md_op=3 a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- md_op=4 a=7 b=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- md_op=5 a=0x1234 -> hi=0x1234 next edge, busy never rises. Then md_op=6 with cancel=1 -> lo unchanged.
- Start mult, pulse start with md_op=6 a=0xAA and cancel=1 mid-RUN, then assert reset at cycle 3 of RUN -> mid-RUN start ignored, cancel ignored; after reset busy=0, hi=lo=0 immediately, and no commit follows.
